// File: rtl/mirror_frame_arbiter.sv
// Purpose: frame-granular round-robin arbiter + raster sequencer sharing one mirror datapath between two pixel sources.
// Latency: pixel accepted at edge A appears on out_* after A; frame_done pulses drain_cycles edges after the last accept.
// Backpressure: only the granted source sees ready (registered decode, STREAM only); missing valid simply stalls the raster.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req0/req1, mode0/mode1     whole-frame requests and the mirror mode sampled at grant
//   sN_valid/sN_data/sN_ready  per-source pixel handshake
//   grant                      one-hot frame owner, 00 when idle
//   out_enable/out_data/out_count_x/out_count_y/out_mode   pixel strobe with raster coordinates and latched mode
//   busy, frame_done, done_id  frame status; done_id is valid with the frame_done pulse
module mirror_frame_arbiter #(
    parameter int data_width    = 8,
    parameter int im_width      = 320,
    parameter int im_height     = 464,
    parameter int im_width_bits = 9,
    parameter int drain_cycles  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [1:0]               mode0,
    input  logic [1:0]               mode1,
    input  logic                     s0_valid,
    input  logic                     s1_valid,
    input  logic [data_width-1:0]    s0_data,
    input  logic [data_width-1:0]    s1_data,
    output logic                     s0_ready,
    output logic                     s1_ready,
    output logic [1:0]               grant,
    output logic                     out_enable,
    output logic [data_width-1:0]    out_data,
    output logic [im_width_bits-1:0] out_count_x,
    output logic [im_width_bits-1:0] out_count_y,
    output logic [1:0]               out_mode,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     done_id
);

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_stream = 2'd1;
    localparam logic [1:0] st_drain  = 2'd2;

    localparam int drain_bits = (drain_cycles < 2) ? 1 : $clog2(drain_cycles + 1);

    localparam logic [im_width_bits-1:0] x_last = im_width_bits'(im_width - 1);
    localparam logic [im_width_bits-1:0] y_last = im_width_bits'(im_height - 1);
    localparam logic [drain_bits-1:0]    drain_load = drain_bits'(drain_cycles);
    localparam logic [drain_bits-1:0]    drain_one  = drain_bits'(1);

    logic [1:0]               state;
    logic                     last;
    logic [im_width_bits-1:0] x;
    logic [im_width_bits-1:0] y;
    logic [drain_bits-1:0]    drain_cnt;

    logic                     accept;
    logic                     winner;
    logic [data_width-1:0]    pix;

    // Ready is decoded purely from registers so it never depends on the
    // source's own valid in the same cycle.
    assign s0_ready = (state == st_stream) && grant[0];
    assign s1_ready = (state == st_stream) && grant[1];
    assign busy     = (state != st_idle);

    assign accept = (s0_ready && s0_valid) || (s1_ready && s1_valid);
    assign pix    = grant[1] ? s1_data : s0_data;

    // Contention goes to the source that did not own the previous frame;
    // a lone requester always wins.
    assign winner = (req0 && req1) ? ~last : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= st_idle;
            grant       <= 2'b00;
            last        <= 1'b1;
            x           <= '0;
            y           <= '0;
            drain_cnt   <= '0;
            out_enable  <= 1'b0;
            out_data    <= '0;
            out_count_x <= '0;
            out_count_y <= '0;
            out_mode    <= 2'b00;
            frame_done  <= 1'b0;
            done_id     <= 1'b0;
        end else begin
            out_enable <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                st_idle: begin
                    if (req0 || req1) begin
                        state    <= st_stream;
                        grant    <= winner ? 2'b10 : 2'b01;
                        out_mode <= winner ? mode1 : mode0;
                        x        <= '0;
                        y        <= '0;
                    end
                end
                st_stream: begin
                    if (accept) begin
                        out_enable  <= 1'b1;
                        out_data    <= pix;
                        out_count_x <= x;
                        out_count_y <= y;
                        if (x == x_last) begin
                            x <= '0;
                            y <= y + 1'b1;
                            // Leaving STREAM on the final pixel keeps y from
                            // ever running past the frame height.
                            if (y == y_last) begin
                                state     <= st_drain;
                                drain_cnt <= drain_load;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                st_drain: begin
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt == drain_one) begin
                        state      <= st_idle;
                        frame_done <= 1'b1;
                        done_id    <= grant[1];
                        last       <= grant[1];
                        grant      <= 2'b00;
                    end
                end
                default: begin
                    state <= st_idle;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/mirror_frame_arbiter.md
# mirror_frame_arbiter

Frame-granular arbiter and raster sequencer in front of the `Mirror` stage. It shares one mirror datapath between two pixel sources, each of which requests a whole frame. The block grants one requester per frame and latches that requester's mirror mode. It streams the requester's pixels out with generated `count_x`/`count_y` coordinates, waits a fixed drain period for the downstream pipeline to empty, then signals frame completion and re-arbitrates round-robin.

## Interface
Parameters:
- `data_width`, 8, pixel width
- `im_width`, 320, pixels per line
- `im_height`, 464, lines per frame
- `im_width_bits`, 9, width of both coordinate counters; requires im_width and im_height ≤ 2^im_width_bits
- `drain_cycles`, 2, downstream pipeline latency to wait after the last pixel; must be ≥ 1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  frame request from source 0/1
- `mode0`, `mode1`  in  2  mirror mode of source 0/1, sampled at grant
- `s0_valid`, `s1_valid`  in  1  pixel valid from source 0/1
- `s0_data`, `s1_data`  in  data_width  pixel from source 0/1
- `s0_ready`, `s1_ready`  out  1  pixel accepted when valid && ready
- `grant`  out  2  one-hot owner of the current frame; 00 when idle
- `out_enable`  out  1  pixel strobe to mirror
- `out_data`  out  data_width  pixel to mirror
- `out_count_x`, `out_count_y`  out  im_width_bits  raster coordinates of out_data
- `out_mode`  out  2  latched mode for the current frame
- `busy`  out  1  high in STREAM or DRAIN
- `frame_done`  out  1  one-cycle pulse at frame completion
- `done_id`  out  1  index of the source whose frame completed; valid with frame_done

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE, no request pending: hold.
- IDLE, any req high:
  - Select a winner; the next edge enters STREAM.
  - grant is set one-hot for the winner.
  - out_mode is loaded with the winner's mode.
  - Coordinate counters x and y are cleared to 0.
- Arbitration:
  - Single request: that source wins.
  - Both requesting: the source not granted last wins.
  - After reset, "last" = 1, so source 0 wins first.
- STREAM:
  - sN_ready = (state==STREAM) && grant[N], decoded from registers. The non-granted source's ready is always 0.
  - On an accepting edge (granted valid && ready): out_enable←1, out_data←pixel, out_count_x←x, out_count_y←y.
  - Counter update on acceptance: x←x+1, except at x==im_width-1, where x←0 and y←y+1.
  - Cycles without acceptance: out_enable←0; counters hold.
- Last pixel (x==im_width-1 && y==im_height-1) accepted: enter DRAIN and load the drain counter with drain_cycles.
- DRAIN:
  - out_enable←0 after the last pixel's strobe; ready is 0.
  - The drain counter decrements each edge.
  - At the edge where the counter is 1: go to IDLE, frame_done←1, done_id←owner, grant←00, last←owner.
- Req deassertion during STREAM/DRAIN is ignored; the frame always completes. mode changes after grant are ignored.
- out_count_x, out_count_y, out_data and out_mode hold their last values while out_enable=0.
- Coordinate arithmetic is unsigned im_width_bits wide. No wrap beyond im_height occurs because the FSM leaves STREAM on the last pixel.

## Timing
- Reset (async assert, applied at any time including mid-frame): state IDLE, grant=00, ready=0, out_enable=0, out_data=0, out_count_x=0, out_count_y=0, out_mode=00, busy=0, frame_done=0, done_id=0, last=1, counters=0. The in-flight frame is abandoned.
- Req high in IDLE at edge E → grant and busy high after E; the source's ready is high in the cycle after E.
- Pixel latency: accepted at edge A → out_enable/out_data/coordinates valid in the cycle after A, for exactly one cycle per accepted pixel.
- With valid held high, throughput is 1 pixel/cycle, so a frame occupies im_width·im_height cycles in STREAM.
- Last accept at edge L → frame_done high for one cycle after edge L+drain_cycles; grant=00 in that same cycle.
- Earliest next grant is the edge after frame_done, giving one IDLE cycle between frames.
- frame_done and a new request in the same cycle are legal; the request is arbitrated on the next edge.

## Test plan
Bench parameters: im_width=4, im_height=3, drain_cycles=2.
- Reset then req0=1, mode0=01, s0_valid always high, data=0..11 → grant=01 one edge after req0. out_enable high for 12 consecutive cycles. Coordinates run (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2). out_mode=01. frame_done with done_id=0 two edges after the last accept.
- req0 and req1 both high continuously → frames are granted in the order 0,1,0,1. Each frame_done is followed by exactly one IDLE cycle before the next grant.
- s0_valid toggling every other cycle → 12 strobes spread over about 24 cycles, coordinates gap-free and in order. s1_ready stays 0 throughout.
- mode0 and req0 changed mid-frame → out_mode unchanged and the frame still completes all 12 pixels.
- rst_n pulsed low after pixel 5 → all outputs go to reset values immediately. A subsequent req1 is granted with the counters starting at (0,0).
- Only req1 asserted after reset → source 1 is granted. done_id=1. A following simultaneous req0/req1 grants source 0.
